// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: FSM encoding
// and the opcode/function constants the decoder recognises.
package mc_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// register 0 hardwired to zero.
module mc_regfile
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 32,
    localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs_q [NREG];

    // Register storage; writes to index 0 are dropped so it always reads zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (wa != {AW{1'b0}})) begin
            regs_q[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == {AW{1'b0}}) ? {DATA_W{1'b0}} : regs_q[ra1];
    assign rd2 = (ra2 == {AW{1'b0}}) ? {DATA_W{1'b0}} : regs_q[ra2];

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/WB per instruction, halting
// once the program counter moves past MAX_PC.
module mc_cpu_core
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREG    = 32,
    parameter int PC_W    = 8,
    parameter int MAX_PC  = 14,
    parameter int OUT_REG = 2
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              done,
    output logic [DATA_W-1:0] out_data,
    output logic              invalid
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [AW-1:0] OUT_IDX    = AW'(OUT_REG);
    localparam logic [PC_W:0] MAX_PC_EXT = (PC_W + 1)'(MAX_PC);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, npc_q, npc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d;
    logic [AW-1:0]     wa_q, wa_d;
    logic              we_q, we_d, req_q, req_d, done_q, done_d, inv_q, inv_d;

    logic [AW-1:0]     ra1_s, ra2_s, rs_s, rt_s, rd_s;
    logic [DATA_W-1:0] rd1_s, rd2_s, imm_dw_s;
    logic [PC_W-1:0]   pc_inc_s, br_tgt_s;
    logic [5:0]        opcode_s, func_s;
    logic              rf_we_s;

    assign opcode_s = ir_q[31:26];
    assign func_s   = ir_q[5:0];
    assign rs_s     = ir_q[21 +: AW];
    assign rt_s     = ir_q[16 +: AW];
    assign rd_s     = ir_q[11 +: AW];
    assign imm_dw_s = DATA_W'(signed'(ir_q[15:0]));
    assign pc_inc_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign br_tgt_s = pc_inc_s + PC_W'(signed'(ir_q[15:0]));

    mc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk  (clk),
        .rstn (rstn),
        .ra1  (ra1_s),
        .ra2  (ra2_s),
        .rd1  (rd1_s),
        .rd2  (rd2_s),
        .we   (rf_we_s),
        .wa   (wa_q),
        .wd   (res_q)
    );

    // Next-state, datapath and output computation for the instruction sequencer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        we_d    = we_q;
        wa_d    = wa_q;
        npc_d   = npc_q;
        req_d   = 1'b0;
        done_d  = done_q;
        out_d   = out_q;
        inv_d   = inv_q;
        ra1_s   = rs_s;
        ra2_s   = rt_s;
        rf_we_s = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // An ack is only meaningful once our request is actually visible.
                if (req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_DECODE: begin
                a_d     = rd1_s;
                b_d     = rd2_s;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                we_d    = 1'b0;
                wa_d    = rd_s;
                res_d   = {DATA_W{1'b0}};
                npc_d   = pc_inc_s;
                state_d = ST_WB;
                if (ir_q == 32'h0000_0000) begin
                    we_d = 1'b0;
                end else begin
                    case (opcode_s)
                        OP_RTYPE: begin
                            we_d = 1'b1;
                            case (func_s)
                                FN_ADD:  res_d = a_q + b_q;
                                FN_SUB:  res_d = a_q - b_q;
                                FN_AND:  res_d = a_q & b_q;
                                FN_OR:   res_d = a_q | b_q;
                                FN_SLT:  res_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                                default: begin
                                    we_d  = 1'b0;
                                    inv_d = 1'b1;
                                end
                            endcase
                        end
                        OP_ADDI: begin
                            we_d  = 1'b1;
                            wa_d  = rt_s;
                            res_d = a_q + imm_dw_s;
                        end
                        OP_BEQ: begin
                            if (a_q == b_q) npc_d = br_tgt_s;
                            else            npc_d = pc_inc_s;
                        end
                        OP_BNE: begin
                            if (a_q != b_q) npc_d = br_tgt_s;
                            else            npc_d = pc_inc_s;
                        end
                        OP_J:    npc_d = ir_q[PC_W-1:0];
                        default: inv_d = 1'b1;
                    endcase
                end
            end
            ST_WB: begin
                rf_we_s = we_q;
                ra1_s   = OUT_IDX;
                pc_d    = npc_q;
                if ({1'b0, npc_q} > MAX_PC_EXT) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                    // Forward the result when this very writeback targets the output register.
                    if (we_q && (wa_q == OUT_IDX) && (wa_q != {AW{1'b0}})) out_d = res_q;
                    else                                                  out_d = rd1_s;
                end else begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                end
            end
            ST_HALT: begin
                ra1_s = OUT_IDX;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FETCH;
            pc_q    <= {PC_W{1'b0}};
            npc_q   <= {PC_W{1'b0}};
            ir_q    <= 32'h0000_0000;
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            res_q   <= {DATA_W{1'b0}};
            out_q   <= {DATA_W{1'b0}};
            wa_q    <= {AW{1'b0}};
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            out_q   <= out_d;
            wa_q    <= wa_d;
            we_q    <= we_d;
            req_q   <= req_d;
            done_q  <= done_d;
            inv_q   <= inv_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign done      = done_q;
    assign out_data  = out_q;
    assign invalid   = inv_q;

endmodule

// File: doc/mc_cpu_core.md
MC_CPU_CORE -- requirements
Module: mc_cpu_core

Interface
REQ-001 Parameter DATA_W, default 8: register and ALU datapath width in bits (4..32).
REQ-002 Parameter NREG, default 32: number of architectural registers, a power of 2, at most 32; register index = low log2(NREG) bits of the rs/rt/rd fields.
REQ-003 Parameter PC_W, default 8: program counter width; PC is word-addressed.
REQ-004 Parameter MAX_PC, default 14: last executable instruction address.
REQ-005 Parameter OUT_REG, default 2: register presented on out_data at halt.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rstn  input  1  reset; asynchronous, active-low.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 imem_addr  output  PC_W  fetch address (= PC).
REQ-010 imem_ack  input  1  memory has valid data on imem_rdata this cycle.
REQ-011 imem_rdata  input  32  MIPS-format instruction word.
REQ-012 done  output  1  program finished; sticky until reset.
REQ-013 out_data  output  DATA_W  value of reg[OUT_REG], valid while done=1, else 0.
REQ-014 invalid  output  1  sticky flag: at least one unsupported instruction was seen.

Function
REQ-015 The FSM shall have states FETCH, DECODE, EXEC, WB and HALT, with transitions FETCH->DECODE on imem_ack=1, DECODE->EXEC, EXEC->WB, and WB->FETCH, or WB->HALT when the new PC > MAX_PC; HALT is terminal.
REQ-016 imem_req shall be 1 only in FETCH; imem_addr shall be held stable while imem_req=1; imem_rdata shall be latched on the cycle imem_ack=1, and imem_ack outside FETCH shall be ignored.
REQ-017 Minimum latency shall be 4 cycles per instruction (1-cycle ack), with each extra wait cycle adding 1.
REQ-018 Supported R-type instructions (opcode 0) shall be add 0x20, sub 0x22, and 0x24, or 0x25 and slt 0x2A (signed compare, result 1/0).
REQ-019 Supported I/J instructions shall be addi 0x08, beq 0x04, bne 0x05 and j 0x02.
REQ-020 Word 0x00000000 shall be a NOP: no write, no flag.
REQ-021 Arithmetic shall be modulo 2^DATA_W; the addi immediate shall be sign-extended and then truncated to DATA_W bits.
REQ-022 Register 0 shall read 0 and ignore writes.
REQ-023 The write destination shall be rd for R-type and rt for addi.
REQ-024 Next PC shall be PC+1 by default; for a taken branch, PC+1+sext(imm); for j, jt[PC_W-1:0]; all truncated to PC_W, so wrap-around is silent.
REQ-025 An unknown opcode, or an unknown func with opcode 0, shall set invalid, skip writeback and advance PC+1.
REQ-026 Register writes shall occur only in WB; operands shall be read in DECODE and registered for EXEC.
REQ-027 In HALT, done=1, imem_req=0, out_data=reg[OUT_REG], and no further state changes shall occur.

Reset
REQ-028 While rstn=0: state=FETCH, PC=0, all registers=0, done=0, invalid=0, out_data=0, imem_req=0.
REQ-029 Reset asserted mid-instruction (any state) shall abort it with no register write; fetch of address 0 shall restart on the first rising clk edge after rstn rises.

Structure
REQ-030 Package mc_cpu_pkg shall hold the opcode/func constants and the FSM state encoding.
REQ-031 Sub-module mc_regfile shall provide 2 read ports and 1 write port, parametrised by DATA_W and NREG, with asynchronous active-low reset to 0.

Verification
REQ-032 addi r1,r0,5; addi r2,r1,-3; NOPs to MAX_PC=14 -> done=1, out_data=2, invalid=0.
REQ-033 DATA_W=8: addi r1,r0,127; addi r2,r1,1 -> out_data=0x80; slt r3,r2,r1 -> r3=1.
REQ-034 beq r0,r0,+2 at PC 0 -> next fetch at address 3; instructions at 1-2 never requested.
REQ-035 imem_ack held low 5 cycles at PC 0 -> imem_req and imem_addr=0 stable throughout, instruction executes once.
REQ-036 Opcode 0x3F at PC 1 -> invalid=1 sticky, no register changes, fetch continues at 2.
REQ-037 rstn pulsed low in EXEC of addi r2,r0,9 -> r2 stays 0, next fetch address 0, done=0.
